// File: rtl/coco_timer_multi.sv
// coco_timer_multi: CHANNELS independent prescaled down-counters
// behind a single-cycle register bus, one OR-combined interrupt.
module coco_timer_multi #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 32
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [5:2]  ADD_I,
  input  logic        WE_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    CNT  = 2'b10,
    DONE = 2'b11
  } state_t;

  logic             r_en   [CHANNELS];
  logic [1:0]       r_mode [CHANNELS];
  logic             r_im   [CHANNELS];
  logic [7:0]       r_psc  [CHANNELS];
  logic [WIDTH-1:0] r_pre  [CHANNELS];
  logic [WIDTH-1:0] r_cnt  [CHANNELS];
  logic [7:0]       r_div  [CHANNELS];
  logic             r_pend [CHANNELS];
  state_t           r_st   [CHANNELS];

  logic             w_en   [CHANNELS];
  logic [1:0]       w_mode [CHANNELS];
  logic             w_im   [CHANNELS];
  logic [7:0]       w_psc  [CHANNELS];
  logic [WIDTH-1:0] w_pre  [CHANNELS];
  logic [WIDTH-1:0] w_cnt  [CHANNELS];
  logic [7:0]       w_div  [CHANNELS];
  logic             w_pend [CHANNELS];
  state_t           w_st   [CHANNELS];

  logic             w_wctrl [CHANNELS];
  logic             w_wpre  [CHANNELS];
  logic             w_wsts  [CHANNELS];
  logic             w_term  [CHANNELS];

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      w_en[c]   = r_en[c];
      w_mode[c] = r_mode[c];
      w_im[c]   = r_im[c];
      w_psc[c]  = r_psc[c];
      w_pre[c]  = r_pre[c];
      w_cnt[c]  = r_cnt[c];
      w_div[c]  = r_div[c];
      w_pend[c] = r_pend[c];
      w_st[c]   = r_st[c];
      w_term[c] = 1'b0;

      w_wctrl[c] = WE_I && (ADD_I[5:4] == 2'(c))
                   && (ADD_I[3:2] == 2'b00);
      w_wpre[c]  = WE_I && (ADD_I[5:4] == 2'(c))
                   && (ADD_I[3:2] == 2'b01);
      w_wsts[c]  = WE_I && (ADD_I[5:4] == 2'(c))
                   && (ADD_I[3:2] == 2'b11);

      if (w_wctrl[c]) begin
        w_en[c]   = DAT_I[0];
        w_mode[c] = DAT_I[2:1];
        w_im[c]   = DAT_I[3];
        w_psc[c]  = DAT_I[15:8];
      end
      if (w_wpre[c]) begin
        w_pre[c] = DAT_I[WIDTH-1:0];
      end

      // FSM sees the freshly written enable/mode/prescale
      if (!w_en[c]) begin
        w_st[c] = IDLE;
      end else if (w_wpre[c] &&
                   (r_st[c] == CNT || r_st[c] == DONE)) begin
        w_st[c] = LOAD;
      end else begin
        unique case (r_st[c])
          IDLE: w_st[c] = LOAD;
          LOAD: begin
            w_div[c] = '0;
            if (r_pre[c] == '0) begin
              w_cnt[c]  = '0;
              w_term[c] = 1'b1;
            end else begin
              w_cnt[c] = r_pre[c];
              w_st[c]  = CNT;
            end
          end
          CNT: begin
            if (r_div[c] >= w_psc[c]) begin
              w_div[c] = '0;
              if (r_cnt[c] == WIDTH'(1)) begin
                w_cnt[c]  = '0;
                w_term[c] = 1'b1;
              end else if (r_cnt[c] != '0) begin
                w_cnt[c] = r_cnt[c] - WIDTH'(1);
              end
            end else begin
              w_div[c] = r_div[c] + 8'd1;
            end
          end
          DONE: w_st[c] = DONE;
        endcase
        if (w_term[c]) begin
          w_st[c] = (w_mode[c] == 2'b01) ? LOAD : DONE;
        end
      end

      // a set on the same edge as a clear must win
      if (w_wsts[c] && DAT_I[0]) begin
        w_pend[c] = 1'b0;
      end
      if (w_term[c]) begin
        w_pend[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_I) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (RST_I) begin
        r_en[c]   <= 1'b0;
        r_mode[c] <= 2'b00;
        r_im[c]   <= 1'b0;
        r_psc[c]  <= '0;
        r_pre[c]  <= '0;
        r_cnt[c]  <= '0;
        r_div[c]  <= '0;
        r_pend[c] <= 1'b0;
        r_st[c]   <= IDLE;
      end else begin
        r_en[c]   <= w_en[c];
        r_mode[c] <= w_mode[c];
        r_im[c]   <= w_im[c];
        r_psc[c]  <= w_psc[c];
        r_pre[c]  <= w_pre[c];
        r_cnt[c]  <= w_cnt[c];
        r_div[c]  <= w_div[c];
        r_pend[c] <= w_pend[c];
        r_st[c]   <= w_st[c];
      end
    end
  end

  always_comb begin
    DAT_O = '0;
    IRQ   = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      IRQ = IRQ | (r_pend[c] & r_im[c]);
      if (ADD_I[5:4] == 2'(c)) begin
        unique case (ADD_I[3:2])
          2'b00: DAT_O = {16'b0, r_psc[c], 4'b0,
                          r_im[c], r_mode[c], r_en[c]};
          2'b01: DAT_O = 32'(r_pre[c]);
          2'b10: DAT_O = 32'(r_cnt[c]);
          2'b11: DAT_O = {29'b0, r_st[c], r_pend[c]};
        endcase
      end
    end
  end

endmodule
